// File: rtl/fetch_pkg.sv
// Shared types and constants for the ARM fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer of {pc, instr} entries.
// Pointers carry one extra MSB so full and empty are distinguishable.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  fill;
  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is data only; it is never reset, validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= push_entry;
  end

  assign fill  = wptr - rptr;
  assign count = CW'(fill);
  assign empty = (wptr == rptr);
  assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/ifetch.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests and
// buffers in-order responses for decode; redirects flush and drop in-flight words.
module ifetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus8,
  output logic        InstrValidF
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic [CW-1:0] rvalid_w;
  logic [CW-1:0] grant_w;
  logic          empty;
  logic          pop;
  logic          push;
  logic          grant;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign pop      = !empty && !StallF;
  assign grant    = imem_req && imem_gnt;
  assign push     = imem_rvalid && !redirect_valid && (drop_cnt == '0);
  assign rvalid_w = {{(CW-1){1'b0}}, imem_rvalid};
  assign grant_w  = {{(CW-1){1'b0}}, grant};

  // Credits cover both buffered and in-flight words, so a response always has a slot.
  assign credit_used = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign imem_req    = !reset && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr   = fetch_pc;

  assign push_entry = {resp_pc, imem_rdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      outstanding <= outstanding - rvalid_w;
      drop_cnt    <= outstanding - rvalid_w;
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (push)  resp_pc  <= resp_pc + 32'd4;
      outstanding <= outstanding + grant_w - rvalid_w;
      if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head),
    .empty      (empty)
  );

  // With an empty buffer, resp_pc is exactly the PC the next head will carry.
  assign InstrValidF = !empty;
  assign InstrF      = empty ? NOP_INSTR : head.instr;
  assign PCF         = empty ? resp_pc : head.pc;
  assign PCPlus8     = PCF + 32'd8;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: variable-latency memory model plus a
// scoreboard of expected {pc, instr} words filled as requests are granted.
module tb_ifetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus8;
  logic        InstrValidF;

  always #5 clk = ~clk;

  ifetch #(
    .RESET_PC   (32'h0000_0100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .StallF         (StallF),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .InstrF         (InstrF),
    .PCF            (PCF),
    .PCPlus8        (PCPlus8),
    .InstrValidF    (InstrValidF)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    bit          stall;
    bit          exp_req;
    bit          exp_valid;
    logic [31:0] exp_pcf;
  } vec_t;

  mreq_t       rq[$];
  exp_t        sb[$];
  vec_t        tbl[10];
  int          cyc;
  int          lat;
  bit          gnt_ok;
  logic [31:0] exp_fetch_pc;
  int          nvec;
  int          nfail;
  bit          found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle: drive memory, score outputs, advance to the next negedge.
  task automatic cycle();
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(rq[0].addr);
      rq.delete(0);
    end
    imem_gnt = imem_req && gnt_ok;
    #1;
    if (InstrValidF) begin
      if (sb.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL sb_empty: head pc %h valid, expected no word", PCF);
      end else begin
        check("head_pc", PCF, sb[0].pc);
        check("head_instr", InstrF, sb[0].instr);
        check("pcplus8", PCPlus8, sb[0].pc + 32'd8);
        if (!StallF) sb.delete(0);
      end
    end else begin
      check("empty_instr", InstrF, NOP_INSTR);
    end
    if (imem_gnt) begin
      check("req_addr", imem_addr, exp_fetch_pc);
      sb.push_back('{exp_fetch_pc, mem_word(exp_fetch_pc)});
      rq.push_back('{imem_addr, cyc + lat});
      exp_fetch_pc += 32'd4;
    end
    if (redirect_valid) begin
      check("req_on_redirect", imem_req, 32'd0);
      sb.delete();
      exp_fetch_pc = redirect_pc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] pc);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      #1;
      if (InstrValidF) found = 1'b1;
      else cycle();
    end
    nvec++;
    if (!found) begin
      nfail++;
      $display("FAIL %s: no valid head within 12 cycles, expected pc %h", name, pc);
    end else begin
      check({name, "_pc"}, PCF, pc);
      check({name, "_instr"}, InstrF, mem_word(pc));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, InstrValidF, 32'd0);
    check({name, "_instr"}, InstrF, NOP_INSTR);
    check({name, "_pcf"}, PCF, 32'h100);
    check({name, "_pc8"}, PCPlus8, 32'h108);
    check({name, "_req"}, imem_req, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nvec = 0; nfail = 0; cyc = 0; lat = 1; gnt_ok = 1'b1;
    reset = 1'b1; StallF = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    exp_fetch_pc = 32'h100;

    // stall, exp_req, exp_valid, exp_pcf: startup then a 3-cycle stall, 1-cycle memory
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h100};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h100};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h100};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h104};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h108};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h108};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h108};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h108};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 32'h10C};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 32'h110};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      StallF = tbl[i].stall;
      #1;
      check("tbl_req", imem_req, tbl[i].exp_req);
      check("tbl_valid", InstrValidF, tbl[i].exp_valid);
      check("tbl_pcf", PCF, tbl[i].exp_pcf);
      cycle();
    end

    // Fill the FIFO under stall, then redirect while full and stalled.
    StallF = 1'b1;
    repeat (2) cycle();
    #1;
    check("full_req", imem_req, 32'd0);
    check("full_valid", InstrValidF, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("flush_valid", InstrValidF, 32'd0);
    check("flush_instr", InstrF, NOP_INSTR);
    check("redir_req", imem_req, 32'd1);
    check("redir_addr", imem_addr, 32'h500);
    cycle();
    #1;
    check("redir_n2_valid", InstrValidF, 32'd0);
    cycle();
    #1;
    check("redir_n3_valid", InstrValidF, 32'd1);
    check("redir_n3_pcf", PCF, 32'h500);
    check("redir_n3_instr", InstrF, mem_word(32'h500));
    StallF = 1'b0;
    repeat (6) cycle();

    // Redirect with one outstanding word returning in the same cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    cycle();
    redirect_valid = 1'b0;
    wait_valid("rv_redir", 32'h400);
    repeat (4) cycle();

    // 3-cycle memory: redirect with three requests in flight.
    lat = 3;
    repeat (10) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    cycle();
    redirect_valid = 1'b0;
    wait_valid("lat3_redir", 32'h400);
    repeat (6) cycle();

    // Randomised traffic: stalls, withheld grants, varying latency, redirects.
    for (int i = 0; i < 400; i++) begin
      StallF         = ($urandom_range(0, 3) == 0);
      gnt_ok         = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 3);
      redirect_valid = (i == 0) || ($urandom_range(0, 19) == 0);
      redirect_pc    = (i == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      cycle();
    end
    redirect_valid = 1'b0;
    StallF = 1'b0;
    gnt_ok = 1'b1;
    lat = 1;
    repeat (8) cycle();

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    rq.delete();
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    exp_fetch_pc = 32'h100;
    #1;
    check("restart_req", imem_req, 32'd1);
    check("restart_addr", imem_addr, 32'h100);
    wait_valid("restart", 32'h100);
    repeat (8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
